// File: rtl/ws2812_rgb_driver_pkg.sv
// Shared types, default WS2812 timing at 50 MHz and timer sizing helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ws2812_defs;

    // One LED colour word as it goes on the wire: G first, then R, then B.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // Default symbol timing in clk cycles at 50 MHz.
    localparam int DEF_T0H          = 20;
    localparam int DEF_T0L          = 43;
    localparam int DEF_T1H          = 40;
    localparam int DEF_T1L          = 23;
    localparam int DEF_RESET_CYCLES = 15000;

    // Word-level shifter state held by the top level.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_RESET
    } drv_state_t;

    // Phase of the single symbol currently on the line.
    typedef enum logic [1:0] {
        SYM_IDLE,
        SYM_HIGH,
        SYM_LOW
    } sym_phase_t;

    function automatic int max_of(input int a, input int b, input int c,
                                  input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Down-counters load the full value and count to 1, so one spare bit
    // beyond $clog2 keeps exact powers of two representable.
    function automatic int timer_width(input int a, input int b, input int c,
                                       input int d, input int e);
        return $clog2(max_of(a, b, c, d, e)) + 1;
    endfunction

endpackage

// File: rtl/ws2812_rgb_driver_if.sv
// Colour-word handshake between the LED controller and the WS2812 driver.
// Latency: n/a (wiring only).
// Backpressure: driver accepts a word only while its one-word buffer is empty.
interface ws2812_rgb_driver_if;
    import ws2812_defs::*;

    logic ready;
    grb_t color;
    logic busy;
    logic data_latched;

    // Controller side: offers words, watches the latch pulse and busy.
    modport master (
        output ready,
        output color,
        input  busy,
        input  data_latched
    );

    // Driver side.
    modport slave (
        input  ready,
        input  color,
        output busy,
        output data_latched
    );

endinterface

// File: rtl/ws2812_rgb_driver_symbol_gen.sv
// Generates one WS2812 symbol: T1H/T0H cycles high then T1L/T0L cycles low.
// Latency: led_out rises on the edge that samples start; done is high in the last low cycle.
// Backpressure: none; start is only legal while idle or in the done cycle, giving gap-free symbols.
module ws2812_symbol_gen
    import ws2812_defs::*;
#(
    parameter int T0H = DEF_T0H,
    parameter int T0L = DEF_T0L,
    parameter int T1H = DEF_T1H,
    parameter int T1L = DEF_T1L
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic led_out,
    output logic done
);

    localparam int TW = timer_width(T0H, T0L, T1H, T1L, 1);

    sym_phase_t    phase_q;
    sym_phase_t    phase_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          bit_q;

    // Phase sequencing: count each phase down to 1, then move on; a start
    // overrides everything so the next symbol follows without a gap.
    always_comb begin
        phase_d = phase_q;
        tmr_d   = tmr_q;
        done    = 1'b0;
        case (phase_q)
            SYM_HIGH: begin
                if (tmr_q == TW'(1)) begin
                    phase_d = SYM_LOW;
                    tmr_d   = bit_q ? TW'(T1L) : TW'(T0L);
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            SYM_LOW: begin
                if (tmr_q == TW'(1)) begin
                    done    = 1'b1;
                    phase_d = SYM_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                phase_d = SYM_IDLE;
            end
        endcase
        if (start) begin
            phase_d = SYM_HIGH;
            tmr_d   = bit_val ? TW'(T1H) : TW'(T0H);
        end
    end

    // Phase/timer registers; led_out is registered from the next phase so
    // the line level lines up exactly with the phase it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= SYM_IDLE;
            tmr_q   <= '0;
            bit_q   <= 1'b0;
            led_out <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tmr_q   <= tmr_d;
            led_out <= (phase_d == SYM_HIGH);
            if (start) begin
                bit_q <= bit_val;
            end
        end
    end

endmodule

// File: rtl/ws2812_rgb_driver.sv
// Serialises 24-bit GRB words MSB first onto the WS2812 line, then holds the latch low period.
// Latency: ready sampled at edge N -> data_latched at N+1 -> led_out high at N+2 from idle.
// Backpressure: one-word buffer; ready is ignored while it is full and for one cycle after a capture.
module ws2812_rgb_driver
    import ws2812_defs::*;
#(
    parameter int T0H          = DEF_T0H,
    parameter int T0L          = DEF_T0L,
    parameter int T1H          = DEF_T1H,
    parameter int T1L          = DEF_T1L,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    ws2812_rgb_driver_if.slave     up,
    output logic                   led_out
);

    localparam int RTW = timer_width(T0H, T0L, T1H, T1L, RESET_CYCLES);

    drv_state_t     state_q;
    drv_state_t     state_d;

    // Input buffer and handshake.
    grb_t           buf_q;
    logic           buf_valid_q;
    logic           latched_q;
    logic           capture;

    // Word shifter: bit 23 goes out straight from the buffer on load, so only
    // the remaining 23 bits are kept here, next bit always at [22].
    logic [22:0]    shift_q;
    logic [4:0]     bit_idx_q;
    logic [RTW-1:0] rst_tmr_q;

    logic           load_word;
    logic           next_bit;
    logic           enter_reset;
    logic           sym_start;
    logic           sym_bit;
    logic           sym_done;

    // The holdoff on latched_q swallows the stale ready the controller keeps
    // up for one cycle after it sees the pulse.
    assign capture         = up.ready && !buf_valid_q && !latched_q;
    assign up.data_latched = latched_q;
    assign up.busy         = (state_q != ST_IDLE) || buf_valid_q;

    // Word-level next state: start words, advance bits, chain buffered words
    // without a gap, or fall into the latch low period.
    always_comb begin
        state_d     = state_q;
        load_word   = 1'b0;
        next_bit    = 1'b0;
        enter_reset = 1'b0;
        sym_start   = 1'b0;
        sym_bit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (buf_valid_q) begin
                    load_word = 1'b1;
                    sym_start = 1'b1;
                    sym_bit   = buf_q.g[7];
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sym_done) begin
                    if (bit_idx_q != 5'd0) begin
                        next_bit  = 1'b1;
                        sym_start = 1'b1;
                        sym_bit   = shift_q[22];
                    end else if (buf_valid_q) begin
                        load_word = 1'b1;
                        sym_start = 1'b1;
                        sym_bit   = buf_q.g[7];
                    end else begin
                        enter_reset = 1'b1;
                        state_d     = ST_RESET;
                    end
                end
            end
            ST_RESET: begin
                if (rst_tmr_q == RTW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One-word input buffer and the one-cycle capture pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            latched_q   <= 1'b0;
        end else begin
            latched_q <= capture;
            if (capture) begin
                buf_q       <= up.color;
                buf_valid_q <= 1'b1;
            end else if (load_word) begin
                buf_valid_q <= 1'b0;
            end
        end
    end

    // Shift register and bit counter for the word on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else if (load_word) begin
            shift_q   <= buf_q[22:0];
            bit_idx_q <= 5'd23;
        end else if (next_bit) begin
            shift_q   <= {shift_q[21:0], 1'b0};
            bit_idx_q <= bit_idx_q - 5'd1;
        end
    end

    // Latch low period counter, loaded as the last bit of a frame ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_tmr_q <= '0;
        end else if (enter_reset) begin
            rst_tmr_q <= RTW'(RESET_CYCLES);
        end else if (rst_tmr_q != '0) begin
            rst_tmr_q <= rst_tmr_q - RTW'(1);
        end
    end

    ws2812_symbol_gen #(
        .T0H (T0H),
        .T0L (T0L),
        .T1H (T1H),
        .T1L (T1L)
    ) u_symbol_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (sym_start),
        .bit_val (sym_bit),
        .led_out (led_out),
        .done    (sym_done)
    );

endmodule

// File: tb/tb_ws2812_rgb_driver.sv
// Randomised bench: records the line every cycle and checks it against waveforms built from the words offered.
// Latency: n/a.
// Backpressure: the bench plays the controller (ready held until the pulse, one stale cycle after).
module tb_ws2812_rgb_driver;
    import ws2812_defs::*;

    localparam int P_T0H = 2;
    localparam int P_T0L = 4;
    localparam int P_T1H = 4;
    localparam int P_T1L = 2;
    localparam int P_RST = 10;
    localparam int HMAX  = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led_out;

    ws2812_rgb_driver_if bus();

    ws2812_rgb_driver #(
        .T0H          (P_T0H),
        .T0L          (P_T0L),
        .T1H          (P_T1H),
        .T1L          (P_T1L),
        .RESET_CYCLES (P_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .up      (bus),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    int   cyc     = 0;
    int   n_pulse = 0;
    int   n_chk   = 0;
    int   n_err   = 0;
    logic led_hist  [HMAX];
    logic busy_hist [HMAX];
    logic [23:0] frame_q [$];

    // Cycle index: the sample taken after edge k is stored at index k.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HMAX) begin
            led_hist[cyc]  = led_out;
            busy_hist[cyc] = bus.busy;
        end
        if (bus.data_latched) n_pulse++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] rand_word();
        logic [31:0] r;
        r = $urandom();
        return r[23:0];
    endfunction

    function automatic int hi_of(input logic b);
        return b ? P_T1H : P_T0H;
    endfunction

    function automatic int lo_of(input logic b);
        return b ? P_T1L : P_T0L;
    endfunction

    function automatic int word_len(input logic [23:0] w);
        int n;
        n = 0;
        for (int i = 0; i < 24; i++) n += hi_of(w[i]) + lo_of(w[i]);
        return n;
    endfunction

    function automatic int run_len(input int p, input logic v, input int cap);
        int n;
        n = 0;
        while (n < cap && (p + n) < HMAX && led_hist[p + n] == v) n++;
        return n;
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Controller behaviour: hold ready until the pulse is seen, keep it one more cycle.
    task automatic offer(input logic [23:0] w, output int pc);
        int n;
        n          = 0;
        pc         = -1;
        bus.color  = w;
        bus.ready  = 1'b1;
        while (pc < 0 && n < 1000) begin
            @(negedge clk);
            if (bus.data_latched) pc = cyc;
            n++;
        end
        if (pc < 0) chk("latch_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        bus.color = rand_word();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    // Expected line for frame_q starting at sample 'start': per bit TxH high
    // then TxL low, MSB first, last bit's low merging into the latch period.
    task automatic check_frame(input int start, input bit idle_after, output int e);
        int   p;
        logic b;
        bit   last;
        p = start;
        chk("start_prev_low", led_hist[start - 1], 0);
        for (int w = 0; w < frame_q.size(); w++) begin
            for (int i = 23; i >= 0; i--) begin
                b    = frame_q[w][i];
                last = (w == frame_q.size() - 1) && (i == 0);
                chk($sformatf("w%0d_b%0d_hi", w, i), run_len(p, 1'b1, hi_of(b) + 2), hi_of(b));
                if (!last)
                    chk($sformatf("w%0d_b%0d_lo", w, i), run_len(p + hi_of(b), 1'b0, lo_of(b) + 2), lo_of(b));
                else
                    chk("latch_low", run_len(p + hi_of(b), 1'b0, lo_of(b) + P_RST), lo_of(b) + P_RST);
                p += hi_of(b) + lo_of(b);
            end
        end
        e = p + P_RST;
        chk("busy_in_latch", busy_hist[e - 1], 1);
        if (idle_after) chk("busy_after_latch", busy_hist[e], 0);
    endtask

    initial begin
        int pc, pc2, pc3, s, e, c0, np0, eexp, p5, nw;
        logic [23:0] w1, w2, w3;

        bus.ready = 1'b1;
        bus.color = 24'hABCDEF;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_led", led_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_latched", bus.data_latched, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", bus.busy, 0);

        // Single word from idle: latency, 4/2 first and last bit, 2/4 in between.
        frame_q.delete();
        frame_q.push_back(24'h800001);
        c0  = cyc;
        np0 = n_pulse;
        offer(24'h800001, pc);
        chk("latch_cycle", pc, c0 + 1);
        wait_idle(2000);
        chk("led_low_at_latch", led_hist[pc], 0);
        check_frame(pc + 1, 1'b1, e);
        chk("pulses_single", n_pulse - np0, 1);

        // Two words back to back; stale ready must not cause a third capture.
        frame_q.delete();
        frame_q.push_back(24'hFFFFFF);
        frame_q.push_back(24'h000000);
        np0 = n_pulse;
        offer(24'hFFFFFF, pc);
        offer(24'h000000, pc2);
        chk("second_capture", pc2, pc + 2);
        wait_idle(2000);
        check_frame(pc + 1, 1'b1, e);
        chk("pulses_pair", n_pulse - np0, 2);

        // Buffer full while shifting: third word held off until the buffer drains.
        w1 = rand_word();
        w2 = rand_word();
        w3 = rand_word();
        frame_q.delete();
        frame_q.push_back(w1);
        frame_q.push_back(w2);
        frame_q.push_back(w3);
        np0 = n_pulse;
        offer(w1, pc);
        offer(w2, pc2);
        offer(w3, pc3);
        chk("full_hold_capture", pc3, pc + 1 + word_len(w1) + 1);
        chk("pulses_full", n_pulse - np0, 3);
        wait_idle(3000);
        check_frame(pc + 1, 1'b1, e);

        // Word offered during the latch period waits, then starts a new frame.
        w1 = rand_word();
        w2 = rand_word();
        offer(w1, pc);
        eexp = pc + 1 + word_len(w1) + P_RST;
        wait_cyc(eexp - 6);
        offer(w2, pc2);
        chk("capture_in_latch", pc2, eexp - 5);
        wait_idle(3000);
        frame_q.delete();
        frame_q.push_back(w1);
        check_frame(pc + 1, 1'b0, e);
        chk("latch_end_cycle", e, eexp);
        chk("busy_with_queued", busy_hist[e], 1);
        chk("idle_gap_low", led_hist[e], 0);
        frame_q.delete();
        frame_q.push_back(w2);
        check_frame(e + 1, 1'b1, e);

        // Synchronous reset in the middle of bit 5, then a clean new word.
        w1 = rand_word();
        offer(w1, pc);
        p5 = pc + 1;
        for (int i = 23; i > 5; i--) p5 += hi_of(w1[i]) + lo_of(w1[i]);
        wait_cyc(p5 + 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midbit_was_high", led_hist[p5 + 1], 1);
        chk("midrst_led", led_out, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_latched", bus.data_latched, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        w2 = rand_word();
        frame_q.delete();
        frame_q.push_back(w2);
        np0 = n_pulse;
        offer(w2, pc);
        wait_idle(2000);
        check_frame(pc + 1, 1'b1, e);
        chk("pulses_after_rst", n_pulse - np0, 1);

        // Random frames of one to three words with random idle gaps.
        for (int k = 0; k < 4; k++) begin
            nw  = $urandom_range(1, 3);
            np0 = n_pulse;
            frame_q.delete();
            s = 0;
            for (int j = 0; j < nw; j++) begin
                w1 = rand_word();
                frame_q.push_back(w1);
                offer(w1, pc);
                if (j == 0) s = pc + 1;
            end
            wait_idle(3000);
            check_frame(s, 1'b1, e);
            chk("pulses_rand", n_pulse - np0, nw);
            repeat ($urandom_range(0, 7)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
